// File: rtl/lamp_ctrl_nway.sv
// N-way staircase lamp controller: debounced switches, toggle-on-change
// lamp register, optional auto-off timer and master off.
module lamp_ctrl_nway #(
    parameter int N_SW    = 3,
    parameter int DEB_CYC = 4,
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_SW-1:0] sw,
    input  logic            all_off,
    output logic            F,
    output logic [N_SW-1:0] sw_stable,
    output logic            timeout
);

    localparam int CW = $clog2(DEB_CYC + 1);
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYC - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam bit AUTO_OFF = (TIMEOUT != 0);

    typedef enum logic {
        OFF = 1'b0,
        ON  = 1'b1
    } state_t;

    logic [N_SW-1:0] sync1;
    logic [N_SW-1:0] sync2;
    logic [N_SW-1:0] stable_d;
    logic [CW-1:0]   cnt [N_SW];
    logic [N_SW-1:0] chg;
    logic            tog;

    state_t          state_q;
    state_t          state_d;
    logic [TW-1:0]   timer_q;
    logic [TW-1:0]   timer_d;
    logic            timeout_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1     <= '0;
            sync2     <= '0;
            sw_stable <= '0;
            stable_d  <= '0;
            for (int i = 0; i < N_SW; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1    <= sw;
            sync2    <= sync1;
            stable_d <= sw_stable;
            for (int i = 0; i < N_SW; i++) begin
                if (sync2[i] == sw_stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == DEB_LAST) begin
                    sw_stable[i] <= sync2[i];
                    cnt[i]       <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Two switches accepted together cancel, as in physical N-way wiring.
    assign chg = sw_stable ^ stable_d;
    assign tog = ^chg;

    always_comb begin
        state_d   = state_q;
        timer_d   = '0;
        timeout_d = 1'b0;
        if (all_off) begin
            state_d = OFF;
        end else if (tog) begin
            state_d = (state_q == ON) ? OFF : ON;
        end else if (state_q == ON && AUTO_OFF && timer_q == TMO_LAST) begin
            state_d   = OFF;
            timeout_d = 1'b1;
        end else if (state_q == ON) begin
            timer_d = timer_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= OFF;
            timer_q <= '0;
            timeout <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            timeout <= timeout_d;
        end
    end

    assign F = (state_q == ON);

endmodule

// File: tb/tb_lamp_ctrl_nway.sv
// Randomised and directed bench for lamp_ctrl_nway against a
// sample-window / parity reference model.
module tb_lamp_ctrl_nway;

    localparam int N   = 3;
    localparam int DEB = 4;
    localparam int TMO = 16;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] sw;
    logic         all_off;
    logic         F;
    logic [N-1:0] sw_stable;
    logic         timeout;

    int nv = 0;
    int nm = 0;

    lamp_ctrl_nway #(.N_SW(N), .DEB_CYC(DEB), .TIMEOUT(TMO)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sw       (sw),
        .all_off  (all_off),
        .F        (F),
        .sw_stable(sw_stable),
        .timeout  (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the debounced level flips once the last DEB
    // synchronised samples all disagree with it; the lamp toggles when
    // parity of the debounced levels changes and is forced off TMO edges
    // after it was last switched on.
    logic [N-1:0] m_q1 = '0, m_q2 = '0, m_st = '0, m_std = '0;
    logic [N-1:0] m_win[$];
    logic         m_f = 1'b0, m_to = 1'b0;
    int           n_edge = 0;
    int           on_at = 0;

    task automatic model_step();
        logic         tg;
        logic [N-1:0] nst;
        bit           all;
        n_edge++;
        if (!rst_n) begin
            m_q1 = '0; m_q2 = '0; m_st = '0; m_std = '0;
            m_f = 1'b0; m_to = 1'b0;
            m_win.delete();
            for (int k = 0; k < DEB; k++) m_win.push_back('0);
            return;
        end
        tg = (^m_st) != (^m_std);
        m_win.push_back(m_q2);
        if (m_win.size() > DEB) void'(m_win.pop_front());
        nst = m_st;
        for (int i = 0; i < N; i++) begin
            all = (m_win.size() == DEB);
            foreach (m_win[k]) if (m_win[k][i] == m_st[i]) all = 0;
            if (all) nst[i] = ~m_st[i];
        end
        m_std = m_st;
        m_st  = nst;
        m_q2  = m_q1;
        m_q1  = sw;
        m_to  = 1'b0;
        if (all_off) begin
            m_f = 1'b0;
        end else if (tg) begin
            m_f   = ~m_f;
            on_at = n_edge;
        end else if (m_f && TMO != 0 && n_edge - on_at == TMO) begin
            m_f  = 1'b0;
            m_to = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; sw = 3'b101; all_off = 1'b0;
        repeat (3) tick();
        nv++;
        if ({F, timeout, sw_stable} !== 5'b0) begin
            nm++;
            $display("FAIL reset F=%b to=%b st=%b want 0/0/000", F, timeout, sw_stable);
        end
        rst_n = 1'b1; sw = '0;
        repeat (8) begin
            tick(); nv++;
            if ({F, timeout, sw_stable} !== {m_f, m_to, m_st}) begin
                nm++;
                $display("FAIL reset_model got %b%b%b want %b%b%b", F, timeout, sw_stable, m_f, m_to, m_st);
            end
        end
    endtask

    task automatic test_single();
        sw = 3'b001;
        for (int k = 1; k <= 7; k++) begin
            tick(); nv++;
            if ({F, timeout, sw_stable} !== {m_f, m_to, m_st}) begin
                nm++;
                $display("FAIL single_model k=%0d got %b%b%b want %b%b%b", k, F, timeout, sw_stable, m_f, m_to, m_st);
            end
            if (k == 5 && sw_stable !== 3'b000) begin
                nm++; $display("FAIL single_early st=%b want 000", sw_stable);
            end
            if (k == 6 && (sw_stable !== 3'b001 || F !== 1'b0)) begin
                nm++; $display("FAIL single_t5 st=%b F=%b want 001/0", sw_stable, F);
            end
            if (k == 7 && F !== 1'b1) begin
                nm++; $display("FAIL single_t6 F=%b want 1", F);
            end
        end
        sw = 3'b000;
        for (int k = 1; k <= 7; k++) begin
            tick(); nv++;
            if ({F, timeout, sw_stable} !== {m_f, m_to, m_st}) begin
                nm++;
                $display("FAIL single_off_model k=%0d got %b%b%b want %b%b%b", k, F, timeout, sw_stable, m_f, m_to, m_st);
            end
            if ((k == 6 && F !== 1'b1) || (k == 7 && F !== 1'b0)) begin
                nm++; $display("FAIL single_off k=%0d F=%b", k, F);
            end
        end
    endtask

    task automatic test_parity();
        int bits [4] = '{0, 1, 2, 1};
        logic exp_f [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int j = 0; j < 4; j++) begin
            sw[bits[j]] = ~sw[bits[j]];
            repeat (10) begin
                tick(); nv++;
                if ({F, timeout, sw_stable} !== {m_f, m_to, m_st}) begin
                    nm++;
                    $display("FAIL parity_model got %b%b%b want %b%b%b", F, timeout, sw_stable, m_f, m_to, m_st);
                end
            end
            nv++;
            if (F !== exp_f[j]) begin
                nm++; $display("FAIL parity step=%0d F=%b want %b", j, F, exp_f[j]);
            end
        end
        sw[0] = ~sw[0];
        sw[2] = ~sw[2];
        repeat (10) begin
            tick(); nv++;
            if (F !== 1'b0 || F !== m_f) begin
                nm++; $display("FAIL parity_cancel F=%b want 0 model %b", F, m_f);
            end
        end
    endtask

    task automatic test_glitch();
        bit saw_st = 0, saw_f = 0;
        sw = 3'b010;
        repeat (3) tick();
        sw = 3'b000;
        repeat (12) begin
            tick();
            if (sw_stable[1]) saw_st = 1;
            if (F) saw_f = 1;
        end
        nv++;
        if (saw_st || saw_f || m_st[1] || m_f) begin
            nm++; $display("FAIL glitch3 saw_st=%b saw_f=%b want 0/0", saw_st, saw_f);
        end
        sw = 3'b010;
        repeat (4) tick();
        sw = 3'b000;
        repeat (15) begin
            tick(); nv++;
            if (sw_stable[1]) saw_st = 1;
            if (F) saw_f = 1;
            if ({F, timeout, sw_stable} !== {m_f, m_to, m_st}) begin
                nm++;
                $display("FAIL glitch_model got %b%b%b want %b%b%b", F, timeout, sw_stable, m_f, m_to, m_st);
            end
        end
        nv++;
        if (!saw_st || !saw_f) begin
            nm++; $display("FAIL glitch4 saw_st=%b saw_f=%b want 1/1", saw_st, saw_f);
        end
    endtask

    task automatic test_autooff();
        int c = 0;
        int hi = 0;
        sw[2] = 1'b1;
        do begin tick(); c++; end while (F !== 1'b1 && c < 20);
        nv++;
        if (F !== 1'b1) begin
            nm++; $display("FAIL autooff_on F=%b want 1", F);
        end
        do begin
            tick(); hi++; nv++;
            if ({F, timeout, sw_stable} !== {m_f, m_to, m_st}) begin
                nm++;
                $display("FAIL autooff_model got %b%b%b want %b%b%b", F, timeout, sw_stable, m_f, m_to, m_st);
            end
        end while (F === 1'b1 && hi < 40);
        nv++;
        if (hi != TMO || timeout !== 1'b1) begin
            nm++; $display("FAIL autooff_len on=%0d to=%b want %0d/1", hi, timeout, TMO);
        end
        tick(); nv++;
        if (timeout !== 1'b0 || F !== 1'b0) begin
            nm++; $display("FAIL autooff_pulse to=%b F=%b want 0/0", timeout, F);
        end
    endtask

    task automatic test_toggle_at_timeout();
        int c = 0;
        sw[0] = ~sw[0];
        do begin tick(); c++; end while (F !== 1'b1 && c < 20);
        repeat (9) tick();
        sw[1] = ~sw[1];
        for (int k = 1; k <= 7; k++) begin
            tick(); nv++;
            if ({F, timeout, sw_stable} !== {m_f, m_to, m_st}) begin
                nm++;
                $display("FAIL tot_model k=%0d got %b%b%b want %b%b%b", k, F, timeout, sw_stable, m_f, m_to, m_st);
            end
            if (k == 6 && F !== 1'b1) begin
                nm++; $display("FAIL tot_hold F=%b want 1", F);
            end
            if (k == 7 && (F !== 1'b0 || timeout !== 1'b0)) begin
                nm++; $display("FAIL tot_win F=%b to=%b want 0/0", F, timeout);
            end
        end
    endtask

    task automatic test_all_off();
        int c = 0;
        sw[1] = ~sw[1];
        do begin tick(); c++; end while (F !== 1'b1 && c < 20);
        nv++;
        if (F !== 1'b1) begin
            nm++; $display("FAIL alloff_on F=%b want 1", F);
        end
        all_off = 1'b1;
        sw[0] = ~sw[0];
        repeat (20) begin
            tick(); nv++;
            if (F !== 1'b0 || {F, timeout, sw_stable} !== {m_f, m_to, m_st}) begin
                nm++; $display("FAIL alloff_hold F=%b st=%b want 0/%b", F, sw_stable, m_st);
            end
        end
        nv++;
        if (sw_stable[0] !== sw[0]) begin
            nm++; $display("FAIL alloff_deb st0=%b want %b", sw_stable[0], sw[0]);
        end
        all_off = 1'b0;
        repeat (10) tick();
        nv++;
        if (F !== 1'b0 || m_f !== 1'b0) begin
            nm++; $display("FAIL alloff_replay F=%b want 0", F);
        end
    endtask

    task automatic test_reset_mid();
        int c = 0;
        sw[1] = ~sw[1];
        do begin tick(); c++; end while (F !== 1'b1 && c < 20);
        repeat (7) tick();
        rst_n = 1'b0;
        sw = 3'b111;
        tick(); nv++;
        if ({F, timeout, sw_stable} !== 5'b0) begin
            nm++; $display("FAIL rstmid F=%b to=%b st=%b want 0/0/000", F, timeout, sw_stable);
        end
        rst_n = 1'b1;
        repeat (15) begin
            tick(); nv++;
            if ({F, timeout, sw_stable} !== {m_f, m_to, m_st}) begin
                nm++;
                $display("FAIL rstmid_model got %b%b%b want %b%b%b", F, timeout, sw_stable, m_f, m_to, m_st);
            end
        end
        nv++;
        if (F !== ^sw || sw_stable !== sw) begin
            nm++; $display("FAIL rstmid_parity F=%b st=%b want %b/%b", F, sw_stable, ^sw, sw);
        end
    endtask

    task automatic test_random();
        int hold = 0;
        repeat (600) begin
            if (hold == 0) begin
                sw   = N'($urandom);
                hold = $urandom_range(1, 8);
            end
            hold--;
            all_off = ($urandom_range(0, 19) == 0);
            rst_n   = ($urandom_range(0, 149) != 0);
            tick(); nv++;
            if ({F, timeout, sw_stable} !== {m_f, m_to, m_st}) begin
                nm++;
                $display("FAIL random_model t=%0t got %b%b%b want %b%b%b", $time, F, timeout, sw_stable, m_f, m_to, m_st);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; sw = '0; all_off = 1'b0;
        test_reset();
        test_single();
        test_parity();
        test_glitch();
        test_autooff();
        test_toggle_at_timeout();
        test_all_off();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nv, nm);
        $finish;
    end

endmodule
